// File: rtl/bp_fe_cmd_arbiter.sv
// Merges redirect, control and attaboy command sources into the front-end command stream.
// Latency: input handshake at N -> buffered at N+1 -> presented at N+2; back-to-back one per cycle on yumi.
// Backpressure: redirect/ctrl ready drops while their one-entry buffer is full; attaboys are dropped (and counted) when their FIFO is full.
//
// Ports: redirect_*/ctrl_* are valid/ready inputs, attaboy_* is push-only, fe_cmd_* is the
// valid/yumi output stream, attaboy_drop_cnt_o counts discarded attaboys, busy_o flags pending work.
module bp_fe_cmd_arbiter #(
    parameter int cmd_width_p      = 128,
    parameter int attaboy_els_p    = 4,
    parameter int starve_limit_p   = 8,
    parameter int drop_cnt_width_p = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [cmd_width_p-1:0]      redirect_cmd_i,
    input  logic                        redirect_v_i,
    output logic                        redirect_ready_o,
    input  logic [cmd_width_p-1:0]      ctrl_cmd_i,
    input  logic                        ctrl_v_i,
    output logic                        ctrl_ready_o,
    input  logic [cmd_width_p-1:0]      attaboy_cmd_i,
    input  logic                        attaboy_v_i,
    output logic [cmd_width_p-1:0]      fe_cmd_o,
    output logic                        fe_cmd_v_o,
    input  logic                        fe_cmd_yumi_i,
    output logic [drop_cnt_width_p-1:0] attaboy_drop_cnt_o,
    output logic                        busy_o
);
    localparam int ptr_w    = $clog2(attaboy_els_p);
    localparam int cnt_w    = ptr_w + 1;
    localparam int starve_w = $clog2(starve_limit_p + 1);

    typedef enum logic [0:0] {IDLE, PRESENT} state_e;
    typedef enum logic [1:0] {SEL_REDIR, SEL_CTRL, SEL_ATB} sel_e;

    state_e                   state_q, state_d;
    sel_e                     sel_q, sel_d;
    logic                     redir_full_q, ctrl_full_q;
    logic [cmd_width_p-1:0]   redir_dat_q, ctrl_dat_q;
    logic [cmd_width_p-1:0]   atb_mem_q [attaboy_els_p];
    logic [ptr_w-1:0]         atb_wr_ptr_q, atb_rd_ptr_q;
    logic [cnt_w-1:0]         atb_cnt_q, atb_cnt_d;
    logic [starve_w-1:0]      starve_q, starve_d;
    logic [drop_cnt_width_p-1:0] drop_q;

    logic yumi, pop_redir, pop_ctrl, pop_atb;
    logic push_redir, push_ctrl, atb_full, push_atb, drop_atb;
    logic redir_avail, ctrl_avail, atb_avail, any_avail;
    sel_e pick;

    assign fe_cmd_v_o = (state_q == PRESENT);
    assign yumi       = fe_cmd_yumi_i & fe_cmd_v_o;
    assign pop_redir  = yumi & (sel_q == SEL_REDIR);
    assign pop_ctrl   = yumi & (sel_q == SEL_CTRL);
    assign pop_atb    = yumi & (sel_q == SEL_ATB);

    assign push_redir = redirect_v_i & ~redir_full_q;
    assign push_ctrl  = ctrl_v_i & ~ctrl_full_q;

    // A push into a full FIFO survives only when the head leaves in the same cycle.
    assign atb_full  = (atb_cnt_q == cnt_w'(attaboy_els_p));
    assign push_atb  = attaboy_v_i & (~atb_full | pop_atb);
    assign drop_atb  = attaboy_v_i & atb_full & ~pop_atb;
    assign atb_cnt_d = atb_cnt_q + {{(cnt_w-1){1'b0}}, push_atb} - {{(cnt_w-1){1'b0}}, pop_atb};

    // Availability for re-selection excludes the entry being popped this cycle.
    assign redir_avail = redir_full_q & ~pop_redir;
    assign ctrl_avail  = ctrl_full_q & ~pop_ctrl;
    assign atb_avail   = (atb_cnt_q > {{(cnt_w-1){1'b0}}, pop_atb});
    assign any_avail   = redir_avail | ctrl_avail | atb_avail;

    // Starvation count uses its post-yumi value so the override takes effect on the very next grant.
    always_comb begin
        starve_d = starve_q;
        if ((atb_cnt_q == '0) || pop_atb) begin
            starve_d = '0;
        end else if (yumi && (starve_q < starve_w'(starve_limit_p))) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        pick = SEL_ATB;
        if (atb_avail && (starve_d >= starve_w'(starve_limit_p))) begin
            pick = SEL_ATB;
        end else if (redir_avail) begin
            pick = SEL_REDIR;
        end else if (ctrl_avail) begin
            pick = SEL_CTRL;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (any_avail) begin
                    state_d = PRESENT;
                    sel_d   = pick;
                end
            end
            PRESENT: begin
                if (yumi) begin
                    if (any_avail) begin
                        sel_d = pick;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            sel_q        <= SEL_REDIR;
            redir_full_q <= 1'b0;
            ctrl_full_q  <= 1'b0;
            redir_dat_q  <= '0;
            ctrl_dat_q   <= '0;
            atb_wr_ptr_q <= '0;
            atb_rd_ptr_q <= '0;
            atb_cnt_q    <= '0;
            starve_q     <= '0;
            drop_q       <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            atb_cnt_q <= atb_cnt_d;
            starve_q  <= starve_d;
            if (push_redir) begin
                redir_full_q <= 1'b1;
                redir_dat_q  <= redirect_cmd_i;
            end else if (pop_redir) begin
                redir_full_q <= 1'b0;
            end
            if (push_ctrl) begin
                ctrl_full_q <= 1'b1;
                ctrl_dat_q  <= ctrl_cmd_i;
            end else if (pop_ctrl) begin
                ctrl_full_q <= 1'b0;
            end
            if (push_atb) begin
                atb_wr_ptr_q <= atb_wr_ptr_q + 1'b1;
            end
            if (pop_atb) begin
                atb_rd_ptr_q <= atb_rd_ptr_q + 1'b1;
            end
            if (drop_atb && !(&drop_q)) begin
                drop_q <= drop_q + 1'b1;
            end
        end
    end

    // Storage only; validity is tracked by the count and pointers.
    always_ff @(posedge clk_i) begin
        if (push_atb) begin
            atb_mem_q[atb_wr_ptr_q] <= attaboy_cmd_i;
        end
    end

    always_comb begin
        fe_cmd_o = atb_mem_q[atb_rd_ptr_q];
        case (sel_q)
            SEL_REDIR: fe_cmd_o = redir_dat_q;
            SEL_CTRL:  fe_cmd_o = ctrl_dat_q;
            default:   fe_cmd_o = atb_mem_q[atb_rd_ptr_q];
        endcase
    end

    assign redirect_ready_o   = ~redir_full_q;
    assign ctrl_ready_o       = ~ctrl_full_q;
    assign attaboy_drop_cnt_o = drop_q;
    assign busy_o             = redir_full_q | ctrl_full_q | (atb_cnt_q != '0) | fe_cmd_v_o;

endmodule

// File: tb/tb_bp_fe_cmd_arbiter.sv
// Testbench for bp_fe_cmd_arbiter: directed scenarios with a handshake scoreboard.
// Inputs change 1ns after the rising edge; handshakes are scored on the falling edge.
// Yumi is generated from a mode: manual, always, or every other cycle.
module tb_bp_fe_cmd_arbiter;
    localparam int W = 128;

    logic         clk;
    logic         reset_n_i;
    logic [W-1:0] redirect_cmd_i, ctrl_cmd_i, attaboy_cmd_i, fe_cmd_o;
    logic         redirect_v_i, redirect_ready_o, ctrl_v_i, ctrl_ready_o, attaboy_v_i;
    logic         fe_cmd_v_o, fe_cmd_yumi_i, busy_o;
    logic [7:0]   attaboy_drop_cnt_o;

    int           total = 0;
    int           bad = 0;
    logic [W-1:0] exp_q[$];
    int           yumi_mode = 0;
    logic         yumi_man = 1'b0;
    logic         yumied_last = 1'b0;
    logic         red_auto = 1'b0, ctrl_auto = 1'b0;
    int           red_left = 0, ctrl_left = 0, red_seq = 0, ctrl_seq = 0;

    bp_fe_cmd_arbiter dut (
        .clk_i              (clk),
        .reset_n_i          (reset_n_i),
        .redirect_cmd_i     (redirect_cmd_i),
        .redirect_v_i       (redirect_v_i),
        .redirect_ready_o   (redirect_ready_o),
        .ctrl_cmd_i         (ctrl_cmd_i),
        .ctrl_v_i           (ctrl_v_i),
        .ctrl_ready_o       (ctrl_ready_o),
        .attaboy_cmd_i      (attaboy_cmd_i),
        .attaboy_v_i        (attaboy_v_i),
        .fe_cmd_o           (fe_cmd_o),
        .fe_cmd_v_o         (fe_cmd_v_o),
        .fe_cmd_yumi_i      (fe_cmd_yumi_i),
        .attaboy_drop_cnt_o (attaboy_drop_cnt_o),
        .busy_o             (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign fe_cmd_yumi_i = fe_cmd_v_o & ((yumi_mode == 1) | ((yumi_mode == 2) & ~yumied_last) |
                                         ((yumi_mode == 0) & yumi_man));

    function automatic logic [W-1:0] red_pl(input int n);
        return W'(32'h1000_0000 + n);
    endfunction
    function automatic logic [W-1:0] ctl_pl(input int n);
        return W'(32'h2000_0000 + n);
    endfunction
    function automatic logic [W-1:0] atb_pl(input int n);
        return W'(32'h3000_0000 + n);
    endfunction

    // One clock: score any handshake at the falling edge, then advance to just after the rising edge
    // and run the auto-feeders, which refill redirect/ctrl as soon as ready is seen.
    task automatic cyc();
        logic         hs;
        logic [W-1:0] e;
        @(negedge clk);
        hs = fe_cmd_v_o & fe_cmd_yumi_i;
        if (hs && reset_n_i) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got %h, required no command", fe_cmd_o);
            end else begin
                e = exp_q.pop_front();
                if (fe_cmd_o !== e) begin
                    bad++;
                    $display("FAIL sb_order: got %h, required %h", fe_cmd_o, e);
                end
            end
        end
        @(posedge clk);
        #1;
        yumied_last = hs;
        if (red_auto) begin
            redirect_v_i = 1'b0;
            if (red_left > 0 && redirect_ready_o) begin
                redirect_v_i   = 1'b1;
                redirect_cmd_i = red_pl(red_seq);
                red_seq++;
                red_left--;
            end
        end
        if (ctrl_auto) begin
            ctrl_v_i = 1'b0;
            if (ctrl_left > 0 && ctrl_ready_o) begin
                ctrl_v_i   = 1'b1;
                ctrl_cmd_i = ctl_pl(ctrl_seq);
                ctrl_seq++;
                ctrl_left--;
            end
        end
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        redirect_v_i = 1'b0; ctrl_v_i = 1'b0; attaboy_v_i = 1'b0;
        redirect_cmd_i = '0; ctrl_cmd_i = '0; attaboy_cmd_i = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (fe_cmd_v_o !== 1'b0) begin bad++; $display("FAIL rst_v: got %b required 0", fe_cmd_v_o); end
        total++; if (fe_cmd_o !== '0) begin bad++; $display("FAIL rst_cmd: got %h required 0", fe_cmd_o); end
        total++; if (redirect_ready_o !== 1'b1) begin bad++; $display("FAIL rst_rready: got %b required 1", redirect_ready_o); end
        total++; if (ctrl_ready_o !== 1'b1) begin bad++; $display("FAIL rst_cready: got %b required 1", ctrl_ready_o); end
        total++; if (attaboy_drop_cnt_o !== 8'd0) begin bad++; $display("FAIL rst_drop: got %0d required 0", attaboy_drop_cnt_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b required 0", busy_o); end
        reset_n_i = 1'b1;
        cyc();
        total++; if (fe_cmd_v_o !== 1'b0) begin bad++; $display("FAIL rst_post_v: got %b required 0", fe_cmd_v_o); end
    endtask

    task automatic test_single();
        yumi_mode = 0;
        exp_q.push_back(red_pl(100));
        redirect_cmd_i = red_pl(100);
        redirect_v_i = 1'b1;
        cyc();
        redirect_v_i = 1'b0;
        total++; if (fe_cmd_v_o !== 1'b0) begin bad++; $display("FAIL single_v1: got %b required 0", fe_cmd_v_o); end
        total++; if (redirect_ready_o !== 1'b0) begin bad++; $display("FAIL single_rdy1: got %b required 0", redirect_ready_o); end
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL single_busy1: got %b required 1", busy_o); end
        cyc();
        total++; if (fe_cmd_v_o !== 1'b1) begin bad++; $display("FAIL single_v2: got %b required 1", fe_cmd_v_o); end
        total++; if (fe_cmd_o !== red_pl(100)) begin bad++; $display("FAIL single_cmd2: got %h required %h", fe_cmd_o, red_pl(100)); end
        cyc();
        yumi_man = 1'b1;
        cyc();
        yumi_man = 1'b0;
        total++; if (redirect_ready_o !== 1'b1) begin bad++; $display("FAIL single_rdy4: got %b required 1", redirect_ready_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL single_busy4: got %b required 0", busy_o); end
        total++; if (fe_cmd_v_o !== 1'b0) begin bad++; $display("FAIL single_v4: got %b required 0", fe_cmd_v_o); end
    endtask

    task automatic test_priority();
        yumi_mode = 1;
        exp_q.push_back(red_pl(101));
        exp_q.push_back(ctl_pl(101));
        redirect_cmd_i = red_pl(101); redirect_v_i = 1'b1;
        ctrl_cmd_i = ctl_pl(101);     ctrl_v_i = 1'b1;
        cyc();
        redirect_v_i = 1'b0; ctrl_v_i = 1'b0;
        cyc();
        total++; if (fe_cmd_o !== red_pl(101)) begin bad++; $display("FAIL prio_first: got %h required %h", fe_cmd_o, red_pl(101)); end
        cyc();
        total++; if (fe_cmd_o !== ctl_pl(101)) begin bad++; $display("FAIL prio_second: got %h required %h", fe_cmd_o, ctl_pl(101)); end
        total++; if (fe_cmd_v_o !== 1'b1) begin bad++; $display("FAIL prio_b2b_v: got %b required 1", fe_cmd_v_o); end
        cyc();
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL prio_drain: got %b required 0", busy_o); end
        yumi_mode = 0;
    endtask

    task automatic test_lock();
        yumi_mode = 0;
        exp_q.push_back(ctl_pl(102));
        exp_q.push_back(red_pl(102));
        ctrl_cmd_i = ctl_pl(102); ctrl_v_i = 1'b1;
        cyc();
        ctrl_v_i = 1'b0;
        redirect_cmd_i = red_pl(102); redirect_v_i = 1'b1;
        cyc();
        redirect_v_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (fe_cmd_o !== ctl_pl(102) || fe_cmd_v_o !== 1'b1) begin
                bad++; $display("FAIL lock_hold[%0d]: got %h v=%b required %h v=1", i, fe_cmd_o, fe_cmd_v_o, ctl_pl(102));
            end
            cyc();
        end
        total++; if (redirect_ready_o !== 1'b0) begin bad++; $display("FAIL lock_rbuf: got %b required 0", redirect_ready_o); end
        yumi_man = 1'b1;
        cyc();
        yumi_man = 1'b0;
        total++; if (fe_cmd_o !== red_pl(102)) begin bad++; $display("FAIL lock_next: got %h required %h", fe_cmd_o, red_pl(102)); end
        yumi_man = 1'b1;
        cyc();
        yumi_man = 1'b0;
        total++; if (fe_cmd_v_o !== 1'b0) begin bad++; $display("FAIL lock_idle: got %b required 0", fe_cmd_v_o); end
    endtask

    task automatic test_overflow();
        int expd;
        yumi_mode = 0;
        for (int i = 0; i < 6; i++) begin
            attaboy_cmd_i = atb_pl(i); attaboy_v_i = 1'b1;
            cyc();
            expd = (i >= 4) ? i - 3 : 0;
            total++;
            if (attaboy_drop_cnt_o !== 8'(expd)) begin
                bad++; $display("FAIL ovf_drop[%0d]: got %0d required %0d", i, attaboy_drop_cnt_o, expd);
            end
        end
        total++; if (fe_cmd_o !== atb_pl(0)) begin bad++; $display("FAIL ovf_head: got %h required %h", fe_cmd_o, atb_pl(0)); end
        exp_q.push_back(atb_pl(0));
        attaboy_cmd_i = atb_pl(6);
        yumi_man = 1'b1;
        cyc();
        attaboy_v_i = 1'b0;
        yumi_man = 1'b0;
        total++; if (attaboy_drop_cnt_o !== 8'd2) begin bad++; $display("FAIL ovf_pushpop_drop: got %0d required 2", attaboy_drop_cnt_o); end
        total++; if (fe_cmd_o !== atb_pl(1)) begin bad++; $display("FAIL ovf_head2: got %h required %h", fe_cmd_o, atb_pl(1)); end
        exp_q.push_back(atb_pl(1));
        exp_q.push_back(atb_pl(2));
        exp_q.push_back(atb_pl(3));
        exp_q.push_back(atb_pl(6));
        yumi_mode = 1;
        repeat (6) cyc();
        yumi_mode = 0;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL ovf_drain: got %b required 0", busy_o); end
    endtask

    task automatic test_reset_mid();
        yumi_mode = 0;
        redirect_cmd_i = red_pl(103); redirect_v_i = 1'b1;
        cyc();
        redirect_v_i = 1'b0;
        cyc();
        total++; if (fe_cmd_v_o !== 1'b1) begin bad++; $display("FAIL mid_pre_v: got %b required 1", fe_cmd_v_o); end
        #2;
        reset_n_i = 1'b0;
        #1;
        total++; if (fe_cmd_v_o !== 1'b0) begin bad++; $display("FAIL mid_v: got %b required 0", fe_cmd_v_o); end
        total++; if (redirect_ready_o !== 1'b1) begin bad++; $display("FAIL mid_rready: got %b required 1", redirect_ready_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b required 0", busy_o); end
        total++; if (attaboy_drop_cnt_o !== 8'd0) begin bad++; $display("FAIL mid_drop: got %0d required 0", attaboy_drop_cnt_o); end
        total++; if (fe_cmd_o !== '0) begin bad++; $display("FAIL mid_cmd: got %h required 0", fe_cmd_o); end
        repeat (2) cyc();
        reset_n_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            total++;
            if (fe_cmd_v_o !== 1'b0) begin bad++; $display("FAIL mid_stale[%0d]: got %b required 0", i, fe_cmd_v_o); end
        end
    endtask

    // One attaboy waits while redirect/ctrl keep both buffers refilled; yumi every other cycle
    // so each refill lands before the next re-selection.
    task automatic test_starvation();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(red_pl(200 + i));
            exp_q.push_back(ctl_pl(200 + i));
        end
        exp_q.push_back(atb_pl(50));
        exp_q.push_back(red_pl(204));
        exp_q.push_back(ctl_pl(204));
        red_seq = 200; ctrl_seq = 200; red_left = 5; ctrl_left = 5;
        red_auto = 1'b1; ctrl_auto = 1'b1;
        yumi_mode = 2;
        cyc();
        attaboy_cmd_i = atb_pl(50); attaboy_v_i = 1'b1;
        cyc();
        attaboy_v_i = 1'b0;
        repeat (40) cyc();
        red_auto = 1'b0; ctrl_auto = 1'b0;
        redirect_v_i = 1'b0; ctrl_v_i = 1'b0;
        yumi_mode = 0;
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL starve_left: got %0d pending required 0", exp_q.size()); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL starve_drain: got %b required 0", busy_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_lock();
        test_overflow();
        test_reset_mid();
        test_starvation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bp_fe_cmd_arbiter.md
# bp_fe_cmd_arbiter

Merges the back end's three front-end command sources into the single `fe_cmd` valid/yumi stream consumed by the front-end top:
- redirect class: trap, branch mispredict, state reset;
- control class: icache fence/fill, itlb fill/fence;
- attaboy training.

Redirect and control sources each get a one-entry buffer; attaboys get a small drop-on-overflow FIFO. A lock-until-yumi output FSM uses fixed priority with an anti-starvation override for attaboys.

## Interface
Parameters:
- `cmd_width_p`, default 128: width of one packed FE command.
- `attaboy_els_p`, default 4: attaboy FIFO depth; power of two, ≥2.
- `starve_limit_p`, default 8: number of consecutive non-attaboy grants, with attaboys pending, after which attaboy wins once.
- `drop_cnt_width_p`, default 8: width of the attaboy drop counter.

Ports:
- `clk_i` in, 1: the single clock.
- `reset_n_i` in, 1: reset, asynchronous, active-low.
- `redirect_cmd_i` in, `cmd_width_p`: redirect-class command.
- `redirect_v_i` in, 1: valid for `redirect_cmd_i`.
- `redirect_ready_o` out, 1: redirect buffer empty; transfer occurs on v&ready.
- `ctrl_cmd_i` in, `cmd_width_p`: control-class command.
- `ctrl_v_i` in, 1: valid for `ctrl_cmd_i`.
- `ctrl_ready_o` out, 1: control buffer empty.
- `attaboy_cmd_i` in, `cmd_width_p`: attaboy command.
- `attaboy_v_i` in, 1: attaboy push. There is no backpressure; a push into a full FIFO is dropped.
- `fe_cmd_o` out, `cmd_width_p`: command presented to the front end.
- `fe_cmd_v_o` out, 1: `fe_cmd_o` valid.
- `fe_cmd_yumi_i` in, 1: front end consumed `fe_cmd_o`. Legal only while `fe_cmd_v_o`=1.
- `attaboy_drop_cnt_o` out, `drop_cnt_width_p`: saturating count of dropped attaboys.
- `busy_o` out, 1: any buffer non-empty or `fe_cmd_v_o`=1.

## Operation
Input buffers:
- `redirect_ready_o` = ~redirect_full_r and `ctrl_ready_o` = ~ctrl_full_r. Both are registered and have no same-cycle bypass.
- A buffer frees on the yumi of its own command. Ready rises the next cycle.

Attaboy FIFO:
- Uses `attaboy_els_p` entries with wrap-around read/write pointers plus a count register.
- Push when full and no pop that cycle: entry discarded, drop counter +1, saturating at all-ones.
- Push and pop in the same cycle while full: the push is accepted and nothing is dropped.
- Pop happens on yumi of an attaboy grant.

Output FSM has two states:
- IDLE: `fe_cmd_v_o`=0. If any source is non-empty, latch `sel_r` and go to PRESENT.
- PRESENT: `fe_cmd_v_o`=1 and `fe_cmd_o` = the head of the `sel_r` source.
  - The source is not popped and `sel_r` is frozen until yumi. There is no preemption, even by a newly arrived redirect.
  - On yumi: pop `sel_r`. If another source is non-empty, re-select (excluding the popped entry) and stay in PRESENT. Otherwise go to IDLE.

Selection rules:
- Priority is redirect > ctrl > attaboy.
- `starve_cnt_r` increments on each yumi of a non-attaboy grant while the attaboy FIFO is non-empty.
- `starve_cnt_r` clears on an attaboy grant, or when the FIFO is empty.
- When `starve_cnt_r` ≥ `starve_limit_p` and the FIFO is non-empty, attaboy is selected regardless of other sources. The counter then clears.

`fe_cmd_o` is driven directly from buffer/FIFO storage, so it is stable for the whole PRESENT interval.

## Timing
Reset:
- All outputs are 0 except `redirect_ready_o`=`ctrl_ready_o`=1.
- State IDLE, buffers empty, pointers, count, `starve_cnt_r` and drop counter all 0.
- Assertion mid-operation clears everything immediately (asynchronously), including dropping `fe_cmd_v_o`. The presented command is lost.

Latency and throughput:
- Input handshake in cycle N: the buffer is valid at N+1 and `fe_cmd_v_o`=1 at N+2 (IDLE→PRESENT).
- Yumi in cycle K with another source pending: the next command is presented at K+1, giving one command per cycle back-to-back.
- The source popped at K can accept a new input at K+1. That input is presentable at K+2 at the earliest.
- The drop counter updates the cycle after the dropped push.

## Test plan
- Single redirect: push at cycle 0 → `fe_cmd_v_o`=1 with the same payload at cycle 2. Yumi at 3 → `redirect_ready_o`=1 at 4 and `busy_o`=0 at 4.
- Priority under load: ctrl and redirect pushed in the same cycle, yumi held high → redirect presented first and ctrl on the next cycle. No attaboy is granted in between.
- Lock without preemption: ctrl presented with yumi withheld for 5 cycles, redirect arrives at cycle 1 → `fe_cmd_o` stays the ctrl payload throughout. Redirect is presented the cycle after yumi.
- Overflow (depth 4): 6 attaboy pushes with the output stalled → 4 stored, `attaboy_drop_cnt_o`=2. Push and pop in the same cycle while full → no further drop.
- Starvation (`starve_limit_p`=8): 1 attaboy pending, redirect/ctrl alternated continuously → the attaboy is granted immediately after the 8th non-attaboy yumi.
- Async reset asserted mid-PRESENT, between clock edges → `fe_cmd_v_o` is 0 immediately and all state is cleared. After release, no stale command is presented.
